stream_mux: RTL and testbench
=============================

// Module: stream_mux
// PURPOSE
//  Parametrised N-channel, WIDTH-bit multiplexer with a registered output and valid/ready handshakes.
//  Two selection modes: fixed channel select, or round-robin arbitration across valid channels.
//  Sits between several producer streams and a single consumer.
//  One output register stage gives 1-cycle latency and full throughput of one word per clock.
// PARAMETERS
//  WIDTH   8  data width per channel, >=1
//  NUM_CH  4  number of input channels, >=2
//  SEL_W   (localparam) = $clog2(NUM_CH); width of sel and out_ch
// PORTS
//  clk       in   1              rising-edge clock
//  rst       in   1              synchronous reset, active-high
//  mode      in   1              0 = fixed select via sel; 1 = round-robin
//  sel       in   SEL_W          channel index used when mode=0
//  in_data   in   NUM_CH*WIDTH   channel i occupies bits [i*WIDTH +: WIDTH]
//  in_valid  in   NUM_CH         per-channel data valid
//  in_ready  out  NUM_CH         per-channel accept (combinational)
//  out_data  out  WIDTH          registered output word
//  out_valid out  1              out_data holds a word
//  out_ready in   1              consumer accepts out_data
//  out_ch    out  SEL_W          channel index that out_data came from
// BEHAVIOUR
//  Reset:
//   - Synchronous reset sets out_valid=0, out_data=0, out_ch=0, rr_ptr=NUM_CH-1.
//   - A held, undelivered word is discarded on reset mid-operation.
//   - After reset, the first round-robin grant goes to ch0.
//  Slot availability:
//   - accept = !out_valid || out_ready (combinational).
//   - When out_valid=1 and out_ready=1, the word drains and a new one loads in the same cycle.
//  Grant (combinational, one-hot at most):
//   - mode=0: grant = sel when sel < NUM_CH and in_valid[sel]=1; otherwise no grant.
//   - mode=0: a sel >= NUM_CH never grants.
//   - mode=1: grant the first i with in_valid[i]=1, searching rr_ptr+1, rr_ptr+2, ..., wrapping modulo NUM_CH.
//   - mode=1: the search includes rr_ptr itself last. No valid channel means no grant.
//  Handshakes:
//   - in_ready[i] = accept && grant==i. All other in_ready bits are 0.
//   - A transfer on channel g occurs when in_valid[g] && in_ready[g].
//   - On transfer: out_data <= in_data[g], out_ch <= g, out_valid <= 1.
//   - On transfer in mode=1 only: rr_ptr <= g.
//   - If out_ready=1 and there is no transfer: out_valid <= 0; out_data and out_ch hold their values.
//   - If out_valid=1 and out_ready=0: out_data and out_ch are stable and all in_ready=0.
//  Mode and select changes:
//   - mode and sel are sampled every cycle and affect only the next grant decision.
//   - A word already registered is unaffected. rr_ptr is not modified while mode=0.
//  Other rules:
//   - Latency is 1 cycle from input transfer to out_valid.
//   - No combinational path from in_data to out_data.
//   - in_ready depends on in_valid, mode, sel, rr_ptr, out_valid and out_ready.
// TESTING
//  1. mode=0, sel=1, in_valid=4'b0010, ch1=8'hA5, out_ready=1
//     -> in_ready=4'b0010; next cycle out_valid=1, out_data=A5, out_ch=1.
//  2. Backpressure: out_valid=1, out_ready=0 for 3 cycles, ch1 valid with 8'h3C
//     -> out_data stable, in_ready=0.
//     Raise out_ready -> 3C transfers with no bubble.
//  3. mode=1, all 4 channels valid continuously, out_ready=1
//     -> out_ch sequence 0,1,2,3,0,1; one word per cycle.
//  4. mode=1, only ch0 and ch2 valid -> out_ch alternates 0,2,0,2.
//     Drop ch2 -> only 0.
//  5. NUM_CH=3, mode=0, sel=2'd3, all valid -> in_ready=0 and out_valid stays 0.
//  6. Reset mid-run: rst=1 with out_valid=1 -> next cycle out_valid=0, out_data=0.
//     Release with mode=1 and all valid -> first out_ch=0.

Source files
------------

// File: rtl/stream_mux_if.sv
// ---------------------------------------------------------------------------
// stream_mux_if
// Bundles the producer-side and consumer-side handshake signals of
// stream_mux into one interface.
//   mode      : 0 = fixed select via sel, 1 = round-robin
//   sel       : channel index used in fixed mode
//   in_data   : NUM_CH packed words, channel i at [i*WIDTH +: WIDTH]
//   in_valid  : per-channel valid
//   in_ready  : per-channel accept (driven by the mux)
//   out_data  : registered output word
//   out_valid : out_data holds a word
//   out_ready : consumer accepts out_data
//   out_ch    : channel index that out_data came from
// The master modport is the environment (producers plus consumer).
// The slave modport is the mux.
// ---------------------------------------------------------------------------
interface stream_mux_if #(
  parameter int WIDTH  = 8,
  parameter int NUM_CH = 4
);
  localparam int SEL_W = $clog2(NUM_CH);

  logic                    mode;
  logic [SEL_W-1:0]        sel;
  logic [NUM_CH*WIDTH-1:0] in_data;
  logic [NUM_CH-1:0]       in_valid;
  logic [NUM_CH-1:0]       in_ready;
  logic [WIDTH-1:0]        out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [SEL_W-1:0]        out_ch;

  modport master (
    output mode, sel, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_ch
  );

  modport slave (
    input  mode, sel, in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_ch
  );
endinterface

// File: rtl/stream_mux.sv
// ---------------------------------------------------------------------------
// stream_mux
// N-channel, WIDTH-bit stream multiplexer with one registered output stage.
// It offers fixed-channel selection or round-robin arbitration over the
// valid channels. Each accepted word appears on the output one cycle later.
// The mux sustains one word per clock.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : stream_mux_if.slave carrying all handshake and data signals
// ---------------------------------------------------------------------------
module stream_mux #(
  parameter int WIDTH  = 8,
  parameter int NUM_CH = 4
) (
  input  logic        clk,
  input  logic        rst,
  stream_mux_if.slave bus
);
  localparam int SEL_W = $clog2(NUM_CH);
  localparam int PAD_N = 2 ** SEL_W;

  logic [WIDTH-1:0]  r_out_data;
  logic              r_out_valid;
  logic [SEL_W-1:0]  r_out_ch;
  logic [SEL_W-1:0]  r_rr_ptr;

  logic              w_accept;
  logic              w_xfer;
  logic              w_grant_valid;
  logic [SEL_W-1:0]  w_grant_idx;
  logic              w_fix_hit;
  logic              w_rr_hit;
  logic [SEL_W-1:0]  w_rr_idx;
  logic              w_sel_in_range;
  logic [PAD_N-1:0]  w_valid_pad;
  logic [SEL_W-1:0]  w_cand_idx [NUM_CH];
  logic [NUM_CH-1:0] w_cand_valid;

  // The output slot is free when it is empty or draining this cycle.
  assign w_accept = !r_out_valid || bus.out_ready;

  // Pad in_valid to a power of two so indexing with any sel value is safe.
  // Padding bits are 0, so an out-of-range sel can never find a valid channel.
  assign w_valid_pad    = PAD_N'(bus.in_valid);
  assign w_sel_in_range = ({1'b0, bus.sel} < (SEL_W + 1)'(NUM_CH));
  assign w_fix_hit      = w_sel_in_range && w_valid_pad[bus.sel];

  // Round-robin candidate k is (rr_ptr + 1 + k) mod NUM_CH.
  // Candidate NUM_CH-1 is rr_ptr itself, so it is searched last.
  // rr_ptr < NUM_CH, so a single conditional subtract performs the wrap.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_rr_cand
      logic [SEL_W:0] w_sum;
      assign w_sum = {1'b0, r_rr_ptr} + (SEL_W + 1)'(gi + 1);
      assign w_cand_idx[gi] = (w_sum >= (SEL_W + 1)'(NUM_CH))
                            ? SEL_W'(w_sum - (SEL_W + 1)'(NUM_CH))
                            : SEL_W'(w_sum);
      assign w_cand_valid[gi] = w_valid_pad[w_cand_idx[gi]];
    end
  endgenerate

  // Scan from the last candidate down to the first.
  // The lowest-offset valid candidate is written last, so it wins.
  always_comb begin
    w_rr_hit = 1'b0;
    w_rr_idx = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (w_cand_valid[k]) begin
        w_rr_hit = 1'b1;
        w_rr_idx = w_cand_idx[k];
      end
    end
  end

  always_comb begin
    if (bus.mode) begin
      w_grant_valid = w_rr_hit;
      w_grant_idx   = w_rr_idx;
    end else begin
      w_grant_valid = w_fix_hit;
      w_grant_idx   = bus.sel;
    end
  end

  // A grant always points at a valid channel.
  // A transfer therefore happens exactly when the slot is free and a grant exists.
  assign w_xfer = w_accept && w_grant_valid;

  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ready
      assign bus.in_ready[gi] = w_xfer && (w_grant_idx == SEL_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ch    <= '0;
      r_rr_ptr    <= SEL_W'(NUM_CH - 1);
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_out_data  <= bus.in_data[w_grant_idx * WIDTH +: WIDTH];
      r_out_ch    <= w_grant_idx;
      if (bus.mode) begin
        r_rr_ptr <= w_grant_idx;
      end
    end else if (bus.out_ready) begin
      // Word drained with nothing to replace it.
      // The data and channel registers keep their last values.
      r_out_valid <= 1'b0;
    end
  end

  assign bus.out_data  = r_out_data;
  assign bus.out_valid = r_out_valid;
  assign bus.out_ch    = r_out_ch;
endmodule

// File: tb/tb_stream_mux.sv
module tb_stream_mux;
  localparam int WIDTH  = 8;
  localparam int NUM_CH = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  stream_mux_if #(.WIDTH(WIDTH), .NUM_CH(NUM_CH)) bus ();
  stream_mux_if #(.WIDTH(WIDTH), .NUM_CH(3))      bus3 ();

  stream_mux #(.WIDTH(WIDTH), .NUM_CH(NUM_CH)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  stream_mux #(.WIDTH(WIDTH), .NUM_CH(3)) dut3 (
    .clk(clk),
    .rst(rst),
    .bus(bus3)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: the held output word plus the last channel served in round-robin mode.
  bit         m_valid = 1'b0;
  logic [7:0] m_data  = 8'h00;
  int         m_ch    = 0;
  int         m_last  = NUM_CH - 1;

  // Grant rule.
  // Fixed mode: sel wins if it is in range and valid.
  // Round-robin mode: walk the channels that follow the last served one, wrapping around.
  function automatic int model_grant(bit md, int s, logic [3:0] v, int last);
    int order[$];
    if (!md) begin
      if (s < NUM_CH && v[s]) return s;
      return -1;
    end
    for (int k = 1; k <= NUM_CH; k++) order.push_back((last + k) % NUM_CH);
    foreach (order[j]) if (v[order[j]]) return order[j];
    return -1;
  endfunction

  function automatic logic [3:0] model_ready();
    int g;
    g = model_grant(bus.mode, int'(bus.sel), bus.in_valid, m_last);
    if ((!m_valid || bus.out_ready) && g >= 0) return 4'(1 << g);
    return 4'b0000;
  endfunction

  task automatic model_step();
    int g;
    if (rst) begin
      m_valid = 1'b0;
      m_data  = 8'h00;
      m_ch    = 0;
      m_last  = NUM_CH - 1;
      return;
    end
    g = model_grant(bus.mode, int'(bus.sel), bus.in_valid, m_last);
    if ((!m_valid || bus.out_ready) && g >= 0) begin
      m_valid = 1'b1;
      m_data  = bus.in_data[g*8 +: 8];
      m_ch    = g;
      if (bus.mode) m_last = g;
      $display("[TB] xfer ch=%0d data=%02h", g, m_data);
    end else if (bus.out_ready) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drive(input bit md, input logic [1:0] s, input logic [3:0] v,
                       input logic [31:0] d, input bit ordy, input bit r);
    @(negedge clk);
    bus.mode      = md;
    bus.sel       = s;
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = ordy;
    rst           = r;
    #1;
  endtask

  task automatic test_reset();
    drive(1'b0, 2'd0, 4'b0000, 32'h0, 1'b1, 1'b1);
    tick();
    tick();
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got=%b exp=0", bus.out_valid); end
    tests++; if (bus.out_data !== 8'h00) begin fails++; $display("FAIL reset_data got=%h exp=00", bus.out_data); end
    tests++; if (bus.out_ch !== 2'd0) begin fails++; $display("FAIL reset_ch got=%0d exp=0", bus.out_ch); end
    tests++; if (bus3.out_valid !== 1'b0) begin fails++; $display("FAIL reset3_valid got=%b exp=0", bus3.out_valid); end
  endtask

  task automatic test_fixed_select();
    drive(1'b0, 2'd1, 4'b0010, 32'h0000_A500, 1'b1, 1'b0);
    tests++; if (bus.in_ready !== 4'b0010) begin fails++; $display("FAIL fixed_ready got=%b exp=0010", bus.in_ready); end
    tick();
    tests++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL fixed_valid got=%b exp=1", bus.out_valid); end
    tests++; if (bus.out_data !== 8'hA5) begin fails++; $display("FAIL fixed_data got=%h exp=a5", bus.out_data); end
    tests++; if (bus.out_ch !== 2'd1) begin fails++; $display("FAIL fixed_ch got=%0d exp=1", bus.out_ch); end
    // Drain with nothing new: valid drops, data and channel hold.
    drive(1'b0, 2'd1, 4'b0000, 32'h0, 1'b1, 1'b0);
    tick();
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL drain_valid got=%b exp=0", bus.out_valid); end
    tests++; if (bus.out_data !== 8'hA5) begin fails++; $display("FAIL drain_hold_data got=%h exp=a5", bus.out_data); end
  endtask

  task automatic test_backpressure();
    drive(1'b0, 2'd1, 4'b0010, 32'h0000_1100, 1'b1, 1'b0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 2'd1, 4'b0010, 32'h0000_3C00, 1'b0, 1'b0);
      tests++; if (bus.in_ready !== 4'b0000) begin fails++; $display("FAIL bp_ready[%0d] got=%b exp=0000", i, bus.in_ready); end
      tick();
      tests++; if (bus.out_data !== 8'h11 || bus.out_valid !== 1'b1) begin
        fails++; $display("FAIL bp_hold[%0d] got=%h/%b exp=11/1", i, bus.out_data, bus.out_valid);
      end
    end
    drive(1'b0, 2'd1, 4'b0010, 32'h0000_3C00, 1'b1, 1'b0);
    tests++; if (bus.in_ready !== 4'b0010) begin fails++; $display("FAIL bp_release_ready got=%b exp=0010", bus.in_ready); end
    tick();
    tests++; if (bus.out_data !== 8'h3C || bus.out_valid !== 1'b1) begin
      fails++; $display("FAIL bp_release got=%h/%b exp=3c/1", bus.out_data, bus.out_valid);
    end
    drive(1'b0, 2'd1, 4'b0000, 32'h0, 1'b1, 1'b0);
    tick();
  endtask

  task automatic test_round_robin_all();
    int seq[6] = '{0, 1, 2, 3, 0, 1};
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 2'd0, 4'b1111, 32'h4342_4140, 1'b1, 1'b0);
      tick();
      tests++; if (bus.out_valid !== 1'b1 || int'(bus.out_ch) != seq[i] || bus.out_data !== 8'(8'h40 + seq[i])) begin
        fails++; $display("FAIL rr_all[%0d] got ch=%0d data=%h v=%b exp ch=%0d", i, bus.out_ch, bus.out_data, bus.out_valid, seq[i]);
      end
    end
  endtask

  task automatic test_rr_two();
    int seq[4] = '{0, 2, 0, 2};
    drive(1'b1, 2'd0, 4'b0000, 32'h0, 1'b1, 1'b1);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2'd0, 4'b0101, 32'h0052_0050, 1'b1, 1'b0);
      tick();
      tests++; if (bus.out_valid !== 1'b1 || int'(bus.out_ch) != seq[i]) begin
        fails++; $display("FAIL rr_two[%0d] got ch=%0d v=%b exp ch=%0d", i, bus.out_ch, bus.out_valid, seq[i]);
      end
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 2'd0, 4'b0001, 32'h0052_0050, 1'b1, 1'b0);
      tick();
      tests++; if (bus.out_valid !== 1'b1 || bus.out_ch !== 2'd0) begin
        fails++; $display("FAIL rr_only0[%0d] got ch=%0d v=%b exp ch=0", i, bus.out_ch, bus.out_valid);
      end
    end
  endtask

  task automatic test_bad_sel();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus3.mode = 1'b0; bus3.sel = 2'd3; bus3.in_valid = 3'b111;
      bus3.in_data = 24'h77_66_55; bus3.out_ready = 1'b1;
      #1;
      tests++; if (bus3.in_ready !== 3'b000) begin fails++; $display("FAIL badsel_ready[%0d] got=%b exp=000", i, bus3.in_ready); end
      tick();
      tests++; if (bus3.out_valid !== 1'b0) begin fails++; $display("FAIL badsel_valid[%0d] got=%b exp=0", i, bus3.out_valid); end
    end
    @(negedge clk);
    bus3.sel = 2'd2;
    #1;
    tests++; if (bus3.in_ready !== 3'b100) begin fails++; $display("FAIL sel2_ready got=%b exp=100", bus3.in_ready); end
    tick();
    tests++; if (bus3.out_ch !== 2'd2 || bus3.out_data !== 8'h77) begin
      fails++; $display("FAIL sel2_out got ch=%0d data=%h exp ch=2 data=77", bus3.out_ch, bus3.out_data);
    end
    @(negedge clk);
    bus3.in_valid = 3'b000;
  endtask

  task automatic test_reset_midrun();
    drive(1'b1, 2'd0, 4'b1111, 32'h9392_9190, 1'b0, 1'b0);
    tick();
    tests++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL mid_load got=%b exp=1", bus.out_valid); end
    drive(1'b1, 2'd0, 4'b1111, 32'h9392_9190, 1'b0, 1'b1);
    tick();
    tests++; if (bus.out_valid !== 1'b0 || bus.out_data !== 8'h00 || bus.out_ch !== 2'd0) begin
      fails++; $display("FAIL mid_reset got v=%b data=%h ch=%0d exp 0/00/0", bus.out_valid, bus.out_data, bus.out_ch);
    end
    drive(1'b1, 2'd0, 4'b1111, 32'h9392_9190, 1'b1, 1'b0);
    tick();
    tests++; if (bus.out_valid !== 1'b1 || bus.out_ch !== 2'd0 || bus.out_data !== 8'h90) begin
      fails++; $display("FAIL mid_first got v=%b ch=%0d data=%h exp 1/0/90", bus.out_valid, bus.out_ch, bus.out_data);
    end
  endtask

  task automatic test_random();
    logic [3:0] exp_rdy;
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
            32'($urandom), ($urandom_range(0, 9) < 7), ($urandom_range(0, 39) == 0));
      exp_rdy = model_ready();
      tests++; if (bus.in_ready !== exp_rdy) begin fails++; $display("FAIL rand_ready[%0d] got=%b exp=%b", i, bus.in_ready, exp_rdy); end
      tick();
      tests++; if (bus.out_valid !== m_valid || bus.out_data !== m_data || int'(bus.out_ch) != m_ch) begin
        fails++; $display("FAIL rand_out[%0d] got v=%b d=%h ch=%0d exp v=%b d=%h ch=%0d",
                          i, bus.out_valid, bus.out_data, bus.out_ch, m_valid, m_data, m_ch);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    bus.mode = 1'b0; bus.sel = '0; bus.in_valid = '0; bus.in_data = '0; bus.out_ready = 1'b1;
    bus3.mode = 1'b0; bus3.sel = '0; bus3.in_valid = '0; bus3.in_data = '0; bus3.out_ready = 1'b1;
    test_reset();
    test_fixed_select();
    test_backpressure();
    test_round_robin_all();
    test_rr_two();
    test_bad_sel();
    test_reset_midrun();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
